// File: rtl/uart_tx_if.sv
// Byte-write port of the UART transmitter: CPU-side store strobe plus FIFO status.
// Handshake: wr is valid, !full is ready; a byte transfers on a rising edge where wr && !full.
interface uart_tx_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr;
    logic [7:0]    data;
    logic          full;
    logic [LW-1:0] level;
    logic          busy;

    modport master (output wr, data, input full, level, busy);
    modport slave  (input wr, data, output full, level, busy);
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a small circular FIFO in front of the shift register.
// fsm_state exposes the current frame phase (IDLE/START/DATA/STOP).
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic       clock,
    input  logic       reset,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic [1:0] fsm_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          tx_n, pop, push, tick, full;

    // full is judged before any pop in the same cycle, so a write into a full FIFO is dropped
    assign full = (level == LVL_FULL);
    assign push = bus.wr && !full;
    assign tick = (clk_cnt == CNT_LAST);

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt + CW'(1);
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                if (level != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    clk_cnt_n = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    clk_cnt_n = '0;
                    shift_n   = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    clk_cnt_n = '0;
                    if (level != '0) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                clk_cnt_n = '0;
                state_n   = IDLE;
            end
        endcase
        if (pop) begin
            shift_n = mem[rd_ptr];
        end
        // tx is registered from the next-state view so the line changes on the transition edge
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    assign bus.full   = full;
    assign bus.level  = level;
    assign bus.busy   = (state != IDLE) || (level != '0);
    assign fsm_state  = state;
endmodule
